// File: rtl/secuenciador_captura_vga.sv
// Scans the date/time/timer mux fields into a work bank and publishes a consistent
// snapshot to a display bank read by the VGA character generator.
module secuenciador_captura_vga #(
    parameter int unsigned N_CAMPOS   = 9,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_refresco,
    input  logic [7:0] dato_mux,
    input  logic       am_mux,
    output logic [3:0] seleccion_dato,
    input  logic [3:0] rd_idx,
    output logic [7:0] rd_dato,
    output logic       am_disp,
    output logic       timer_cero,
    output logic       busy,
    output logic       frame_valid
);

    localparam int unsigned CNT_W     = $clog2(SETTLE_CYC + 1);
    localparam int unsigned IDX_HORAS = 3;
    localparam int unsigned IDX_TMR0  = 6;
    localparam int unsigned IDX_TMR1  = 7;
    localparam int unsigned IDX_TMR2  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } estado_t;

    estado_t            estado;
    logic [3:0]         idx;
    logic [CNT_W-1:0]   cnt;
    logic               am_work;
    logic [7:0]         work [N_CAMPOS];
    logic [7:0]         disp [N_CAMPOS];

    // Scan sequencer; the display bank only changes on the DONE edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado         <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            seleccion_dato <= '0;
            am_work        <= 1'b1;
            am_disp        <= 1'b1;
            timer_cero     <= 1'b0;
            busy           <= 1'b0;
            frame_valid    <= 1'b0;
            for (int i = 0; i < int'(N_CAMPOS); i++) begin
                work[i] <= 8'h00;
                disp[i] <= 8'h00;
            end
        end else begin
            frame_valid <= 1'b0;
            case (estado)
                IDLE: begin
                    if (tick_refresco) begin
                        estado         <= SETTLE;
                        idx            <= '0;
                        seleccion_dato <= '0;
                        cnt            <= '0;
                        busy           <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        estado <= CAPTURE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    work[idx] <= dato_mux;
                    if (idx == 4'(IDX_HORAS)) begin
                        am_work <= am_mux;
                    end
                    if (idx == 4'(N_CAMPOS - 1)) begin
                        estado <= DONE;
                    end else begin
                        idx            <= idx + 4'd1;
                        seleccion_dato <= idx + 4'd1;
                        cnt            <= '0;
                        estado         <= SETTLE;
                    end
                end
                DONE: begin
                    for (int i = 0; i < int'(N_CAMPOS); i++) begin
                        disp[i] <= work[i];
                    end
                    am_disp     <= am_work;
                    timer_cero  <= (work[IDX_TMR0] | work[IDX_TMR1] | work[IDX_TMR2]) == 8'h00;
                    frame_valid <= 1'b1;
                    busy        <= 1'b0;
                    estado      <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

    assign rd_dato = (rd_idx < 4'(N_CAMPOS)) ? disp[rd_idx] : 8'h00;

endmodule

// File: tb/tb_secuenciador_captura_vga.sv
// Self-checking bench: a combinational mux model feeds the DUT, and the expected
// snapshot is derived from the scan timing (field k captured 3*(k+1) edges after the tick).
module tb_secuenciador_captura_vga;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_refresco;
    logic [7:0] dato_mux;
    logic       am_mux;
    logic [3:0] seleccion_dato;
    logic [3:0] rd_idx;
    logic [7:0] rd_dato;
    logic       am_disp;
    logic       timer_cero;
    logic       busy;
    logic       frame_valid;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mux_val [9];
    logic       mux_am  [9];
    logic [7:0] exp_disp [9];
    logic       exp_am;
    logic       exp_tz;

    secuenciador_captura_vga dut (
        .clk            (clk),
        .reset          (reset),
        .tick_refresco  (tick_refresco),
        .dato_mux       (dato_mux),
        .am_mux         (am_mux),
        .seleccion_dato (seleccion_dato),
        .rd_idx         (rd_idx),
        .rd_dato        (rd_dato),
        .am_disp        (am_disp),
        .timer_cero     (timer_cero),
        .busy           (busy),
        .frame_valid    (frame_valid)
    );

    always #50 clk = ~clk;

    always_comb begin
        dato_mux = 8'hEE;
        am_mux   = 1'b1;
        if (seleccion_dato < 4'd9) begin
            dato_mux = mux_val[seleccion_dato];
            am_mux   = mux_am[seleccion_dato];
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_display(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            chk($sformatf("%s rd_dato[%0d]", tag, i), 32'(rd_dato),
                (i < 9) ? 32'(exp_disp[i]) : 32'h0);
        end
        chk({tag, " am_disp"}, 32'(am_disp), 32'(exp_am));
        chk({tag, " timer_cero"}, 32'(timer_cero), 32'(exp_tz));
    endtask

    task automatic tick_now();
        @(posedge clk);
        #1;
        tick_refresco = 1'b0;
    endtask

    // One full scan: tick sampled at E0, then 28 cycles checked against timing rules.
    task automatic scan(input string tag, input bit pulse, input int change_at,
                        input logic [7:0] new_val, input int second_tick_at);
        logic [7:0] cap [9];
        logic       cap_am;
        int         ri;
        cap_am = exp_am;
        if (pulse) tick_refresco = 1'b1;
        tick_now();
        for (int n = 0; n <= 28; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            tick_refresco = (n == second_tick_at);
            if (n == change_at) begin
                for (int k = 0; k < 9; k++) mux_val[k] = new_val;
            end
            if ((n % 3) == 2 && (n / 3) < 9) begin
                cap[n/3] = mux_val[n/3];
                if ((n / 3) == 3) cap_am = mux_am[3];
            end
            if (n <= 27) begin
                if (n <= 26)
                    chk($sformatf("%s sel n=%0d", tag, n), 32'(seleccion_dato), 32'(n / 3));
                chk($sformatf("%s busy n=%0d", tag, n), 32'(busy), 32'h1);
                chk($sformatf("%s fv n=%0d", tag, n), 32'(frame_valid), 32'h0);
                ri = $urandom_range(0, 15);
                rd_idx = 4'(ri);
                #1;
                chk($sformatf("%s old snapshot[%0d] n=%0d", tag, ri, n), 32'(rd_dato),
                    (ri < 9) ? 32'(exp_disp[ri]) : 32'h0);
            end else begin
                chk({tag, " fv at 28"}, 32'(frame_valid), 32'h1);
                chk({tag, " busy at 28"}, 32'(busy), 32'h0);
                for (int k = 0; k < 9; k++) exp_disp[k] = cap[k];
                exp_am = cap_am;
                exp_tz = ((cap[6] | cap[7] | cap[8]) == 8'h00);
                check_display(tag);
            end
        end
    endtask

    task automatic randomize_mux();
        for (int k = 0; k < 9; k++) begin
            mux_val[k] = 8'($urandom);
            mux_am[k]  = 1'($urandom);
        end
    endtask

    initial begin
        reset         = 1'b1;
        tick_refresco = 1'b0;
        rd_idx        = 4'd0;
        for (int k = 0; k < 9; k++) begin
            mux_val[k]  = 8'h10 + 8'(k);
            mux_am[k]   = (k != 3);
            exp_disp[k] = 8'h00;
        end
        exp_am = 1'b1;
        exp_tz = 1'b0;

        // 1: reset and hold
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset fv", 32'(frame_valid), 32'h0);
        chk("reset sel", 32'(seleccion_dato), 32'h0);
        check_display("reset");

        // 2: directed pattern 0x10+k, am low only at hours
        scan("directed", 1'b1, -1, 8'h00, -1);
        chk("directed sel holds", 32'(seleccion_dato), 32'h8);

        // 3: mux goes to FF mid-scan; only fields captured afterwards take it
        scan("midchange", 1'b1, 14, 8'hFF, -1);

        // random scans
        for (int r = 0; r < 3; r++) begin
            randomize_mux();
            scan($sformatf("rand%0d", r), 1'b1, -1, 8'h00, -1);
        end

        // 4: timer fields zero, then field 7 = 1
        randomize_mux();
        mux_val[6] = 8'h00; mux_val[7] = 8'h00; mux_val[8] = 8'h00;
        scan("tmr zero", 1'b1, -1, 8'h00, -1);
        chk("tmr zero flag", 32'(timer_cero), 32'h1);
        mux_val[7] = 8'h01;
        scan("tmr nonzero", 1'b1, -1, 8'h00, -1);
        chk("tmr nonzero flag", 32'(timer_cero), 32'h0);

        // 5: tick during scan ignored, then no stray second scan
        randomize_mux();
        scan("ignored tick", 1'b1, -1, 8'h00, 4);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("no requeue busy c=%0d", c), 32'(busy), 32'h0);
            chk($sformatf("no requeue fv c=%0d", c), 32'(frame_valid), 32'h0);
        end
        // tick in the frame_valid cycle starts the next scan immediately
        randomize_mux();
        scan("fv tick", 1'b1, -1, 8'h00, 28);
        randomize_mux();
        scan("back to back", 1'b0, -1, 8'h00, -1);

        // 6: reset mid-scan at cycle 15
        randomize_mux();
        tick_refresco = 1'b1;
        tick_now();
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset busy", 32'(busy), 32'h0);
        chk("midreset sel", 32'(seleccion_dato), 32'h0);
        chk("midreset fv", 32'(frame_valid), 32'h0);
        for (int k = 0; k < 9; k++) exp_disp[k] = 8'h00;
        exp_am = 1'b1;
        exp_tz = 1'b0;
        check_display("midreset");
        randomize_mux();
        scan("after reset", 1'b1, -1, 8'h00, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
